// File: rtl/timer_arbiter.sv
// Two-requester arbiter sharing one 4-bit up-counter; the owner runs until the
// count reaches its latched terminal value, then receives a one-cycle DONE.
//
// state | meaning
// IDLE  | no owner; grant on the next edge if any REQ bit is set
// RUN   | owner holds GNT; Q counts from 0 up to TERM
// FIN   | GNT released, DONE pulses to the owner, Q holds TERM
module timer_arbiter (
  input  logic       CLOCK,
  input  logic       CLEAR,
  input  logic [1:0] REQ,
  input  logic [3:0] LEN0,
  input  logic [3:0] LEN1,
  output logic [1:0] GNT,
  output logic [3:0] Q,
  output logic       BUSY,
  output logic [1:0] DONE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_gnt;
  logic [1:0] w_gnt_nxt;
  logic [3:0] r_q;
  logic [3:0] w_q_nxt;
  logic [1:0] r_done;
  logic [1:0] w_done_nxt;
  logic       r_busy;
  logic       w_busy_nxt;
  logic [3:0] r_term;
  logic [3:0] w_term_nxt;
  logic       r_owner;
  logic       w_owner_nxt;
  logic       r_ptr;
  logic       w_ptr_nxt;

  logic       w_winner;
  logic       w_owner_req;

  // With both requesting, PTR breaks the tie; otherwise the lone requester wins.
  assign w_winner    = (REQ == 2'b11) ? r_ptr : REQ[1];
  assign w_owner_req = REQ[r_owner];

  always_ff @(posedge CLOCK) begin
    if (CLEAR) begin
      r_state <= S_IDLE;
      r_gnt   <= 2'b00;
      r_q     <= 4'd0;
      r_done  <= 2'b00;
      r_busy  <= 1'b0;
      r_term  <= 4'd0;
      r_owner <= 1'b0;
      r_ptr   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_q     <= w_q_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
      r_term  <= w_term_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_q_nxt     = r_q;
    w_done_nxt  = 2'b00;
    w_term_nxt  = r_term;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;

    case (r_state)
      S_IDLE: begin
        if (REQ != 2'b00) begin
          w_state_nxt = S_RUN;
          w_owner_nxt = w_winner;
          w_gnt_nxt   = w_winner ? 2'b10 : 2'b01;
          w_q_nxt     = 4'd0;
          w_term_nxt  = w_winner ? LEN1 : LEN0;
        end
      end
      S_RUN: begin
        // Abort is checked first so a dropped request never earns a DONE.
        if (!w_owner_req) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = 2'b00;
          w_q_nxt     = 4'd0;
          w_ptr_nxt   = ~r_owner;
        end else if (r_q == r_term) begin
          w_state_nxt = S_FIN;
          w_gnt_nxt   = 2'b00;
          w_done_nxt  = {r_owner, ~r_owner};
        end else begin
          w_q_nxt = r_q + 4'd1;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
        w_q_nxt     = 4'd0;
        w_ptr_nxt   = ~r_owner;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 2'b00;
        w_q_nxt     = 4'd0;
      end
    endcase

    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  assign GNT  = r_gnt;
  assign Q    = r_q;
  assign BUSY = r_busy;
  assign DONE = r_done;

endmodule

// File: tb/tb_timer_arbiter.sv
// Directed bench for timer_arbiter: each task drives one scenario cycle by
// cycle and compares {GNT,Q,BUSY,DONE} against hand-derived vectors.
module tb_timer_arbiter;

  logic       CLOCK = 1'b0;
  logic       CLEAR = 1'b1;
  logic [1:0] REQ   = 2'b00;
  logic [3:0] LEN0  = 4'd0;
  logic [3:0] LEN1  = 4'd0;
  logic [1:0] GNT;
  logic [3:0] Q;
  logic       BUSY;
  logic [1:0] DONE;

  int n_cmp = 0;
  int n_mis = 0;

  timer_arbiter dut (
    .CLOCK(CLOCK),
    .CLEAR(CLEAR),
    .REQ  (REQ),
    .LEN0 (LEN0),
    .LEN1 (LEN1),
    .GNT  (GNT),
    .Q    (Q),
    .BUSY (BUSY),
    .DONE (DONE)
  );

  always #10 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // Outputs are sampled 1 time unit after the rising edge; inputs changed
  // there are taken by the following edge.
  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  function automatic logic [8:0] ev(input logic [1:0] g, input logic [3:0] q,
                                    input logic b, input logic [1:0] d);
    return {g, q, b, d};
  endfunction

  task automatic test_reset();
    logic [8:0] e;
    e = ev(2'b00, 4'd0, 1'b0, 2'b00);
    CLEAR = 1'b1;
    REQ   = 2'b11;
    LEN0  = 4'd5;
    LEN1  = 4'd5;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        CLEAR = 1'b0;
        REQ   = 2'b00;
      end
      tick();
      n_cmp++;
      if ({GNT, Q, BUSY, DONE} !== e) begin
        n_mis++;
        $display("FAIL reset[%0d]: got gnt=%b q=%0d busy=%b done=%b, expected gnt=%b q=%0d busy=%b done=%b",
                 i, GNT, Q, BUSY, DONE, e[8:7], e[6:3], e[2], e[1:0]);
      end
    end
  endtask

  task automatic test_single();
    logic [8:0] e [0:6];
    e = '{ev(2'b01, 4'd0, 1'b1, 2'b00), ev(2'b01, 4'd1, 1'b1, 2'b00),
          ev(2'b01, 4'd2, 1'b1, 2'b00), ev(2'b01, 4'd3, 1'b1, 2'b00),
          ev(2'b00, 4'd3, 1'b1, 2'b01), ev(2'b00, 4'd0, 1'b0, 2'b00),
          ev(2'b00, 4'd0, 1'b0, 2'b00)};
    REQ  = 2'b01;
    LEN0 = 4'd3;
    LEN1 = 4'd0;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++;
      if ({GNT, Q, BUSY, DONE} !== e[i]) begin
        n_mis++;
        $display("FAIL single[%0d]: got gnt=%b q=%0d busy=%b done=%b, expected gnt=%b q=%0d busy=%b done=%b",
                 i, GNT, Q, BUSY, DONE, e[i][8:7], e[i][6:3], e[i][2], e[i][1:0]);
      end
      if (i == 4) REQ = 2'b00;
    end
  endtask

  task automatic test_contention();
    logic [8:0] e [0:9];
    e = '{ev(2'b01, 4'd0, 1'b1, 2'b00), ev(2'b01, 4'd1, 1'b1, 2'b00),
          ev(2'b00, 4'd1, 1'b1, 2'b01), ev(2'b00, 4'd0, 1'b0, 2'b00),
          ev(2'b10, 4'd0, 1'b1, 2'b00), ev(2'b10, 4'd1, 1'b1, 2'b00),
          ev(2'b00, 4'd1, 1'b1, 2'b10), ev(2'b00, 4'd0, 1'b0, 2'b00),
          ev(2'b01, 4'd0, 1'b1, 2'b00), ev(2'b00, 4'd0, 1'b0, 2'b00)};
    CLEAR = 1'b1;
    tick();
    CLEAR = 1'b0;
    REQ   = 2'b11;
    LEN0  = 4'd1;
    LEN1  = 4'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if ({GNT, Q, BUSY, DONE} !== e[i]) begin
        n_mis++;
        $display("FAIL contention[%0d]: got gnt=%b q=%0d busy=%b done=%b, expected gnt=%b q=%0d busy=%b done=%b",
                 i, GNT, Q, BUSY, DONE, e[i][8:7], e[i][6:3], e[i][2], e[i][1:0]);
      end
      if (i == 8) REQ = 2'b00;
    end
  endtask

  task automatic test_zero_len();
    logic [8:0] e [0:2];
    e = '{ev(2'b10, 4'd0, 1'b1, 2'b00), ev(2'b00, 4'd0, 1'b1, 2'b10),
          ev(2'b00, 4'd0, 1'b0, 2'b00)};
    REQ  = 2'b10;
    LEN0 = 4'd5;
    LEN1 = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({GNT, Q, BUSY, DONE} !== e[i]) begin
        n_mis++;
        $display("FAIL zero_len[%0d]: got gnt=%b q=%0d busy=%b done=%b, expected gnt=%b q=%0d busy=%b done=%b",
                 i, GNT, Q, BUSY, DONE, e[i][8:7], e[i][6:3], e[i][2], e[i][1:0]);
      end
      if (i == 1) REQ = 2'b00;
    end
  endtask

  task automatic test_abort();
    logic [8:0] e [0:10];
    e = '{ev(2'b01, 4'd0, 1'b1, 2'b00), ev(2'b01, 4'd1, 1'b1, 2'b00),
          ev(2'b01, 4'd2, 1'b1, 2'b00), ev(2'b01, 4'd3, 1'b1, 2'b00),
          ev(2'b01, 4'd4, 1'b1, 2'b00), ev(2'b00, 4'd0, 1'b0, 2'b00),
          ev(2'b10, 4'd0, 1'b1, 2'b00), ev(2'b10, 4'd1, 1'b1, 2'b00),
          ev(2'b10, 4'd2, 1'b1, 2'b00), ev(2'b00, 4'd2, 1'b1, 2'b10),
          ev(2'b00, 4'd0, 1'b0, 2'b00)};
    REQ  = 2'b01;
    LEN0 = 4'd9;
    LEN1 = 4'd2;
    for (int i = 0; i < 11; i++) begin
      tick();
      n_cmp++;
      if ({GNT, Q, BUSY, DONE} !== e[i]) begin
        n_mis++;
        $display("FAIL abort[%0d]: got gnt=%b q=%0d busy=%b done=%b, expected gnt=%b q=%0d busy=%b done=%b",
                 i, GNT, Q, BUSY, DONE, e[i][8:7], e[i][6:3], e[i][2], e[i][1:0]);
      end
      if (i == 4) REQ = 2'b00;
      if (i == 5) REQ = 2'b11;
      if (i == 9) REQ = 2'b00;
    end
  endtask

  // A zero-length run for requester 0 first moves PTR to 1, so the grant
  // after the mid-run clear shows whether PTR really returned to 0.
  task automatic test_reset_mid();
    logic [8:0] e [0:11];
    e = '{ev(2'b01, 4'd0, 1'b1, 2'b00), ev(2'b00, 4'd0, 1'b1, 2'b01),
          ev(2'b00, 4'd0, 1'b0, 2'b00), ev(2'b01, 4'd0, 1'b1, 2'b00),
          ev(2'b01, 4'd1, 1'b1, 2'b00), ev(2'b01, 4'd2, 1'b1, 2'b00),
          ev(2'b01, 4'd3, 1'b1, 2'b00), ev(2'b01, 4'd4, 1'b1, 2'b00),
          ev(2'b01, 4'd5, 1'b1, 2'b00), ev(2'b00, 4'd0, 1'b0, 2'b00),
          ev(2'b01, 4'd0, 1'b1, 2'b00), ev(2'b00, 4'd0, 1'b0, 2'b00)};
    REQ  = 2'b01;
    LEN0 = 4'd0;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if ({GNT, Q, BUSY, DONE} !== e[i]) begin
        n_mis++;
        $display("FAIL reset_mid[%0d]: got gnt=%b q=%0d busy=%b done=%b, expected gnt=%b q=%0d busy=%b done=%b",
                 i, GNT, Q, BUSY, DONE, e[i][8:7], e[i][6:3], e[i][2], e[i][1:0]);
      end
      if (i == 1) REQ = 2'b00;
      if (i == 2) begin
        REQ  = 2'b01;
        LEN0 = 4'd9;
      end
      if (i == 8) CLEAR = 1'b1;
      if (i == 9) begin
        CLEAR = 1'b0;
        REQ   = 2'b11;
      end
      if (i == 10) REQ = 2'b00;
    end
  endtask

  task automatic test_len_stable();
    logic [8:0] e [0:8];
    e = '{ev(2'b01, 4'd0, 1'b1, 2'b00), ev(2'b01, 4'd1, 1'b1, 2'b00),
          ev(2'b01, 4'd2, 1'b1, 2'b00), ev(2'b01, 4'd3, 1'b1, 2'b00),
          ev(2'b01, 4'd4, 1'b1, 2'b00), ev(2'b01, 4'd5, 1'b1, 2'b00),
          ev(2'b01, 4'd6, 1'b1, 2'b00), ev(2'b00, 4'd6, 1'b1, 2'b01),
          ev(2'b00, 4'd0, 1'b0, 2'b00)};
    REQ  = 2'b01;
    LEN0 = 4'd6;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_cmp++;
      if ({GNT, Q, BUSY, DONE} !== e[i]) begin
        n_mis++;
        $display("FAIL len_stable[%0d]: got gnt=%b q=%0d busy=%b done=%b, expected gnt=%b q=%0d busy=%b done=%b",
                 i, GNT, Q, BUSY, DONE, e[i][8:7], e[i][6:3], e[i][2], e[i][1:0]);
      end
      if (i == 1) LEN0 = 4'd2;
      if (i == 7) REQ = 2'b00;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_zero_len();
    test_abort();
    test_reset_mid();
    test_len_stable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 The block SHALL run on one clock, CLOCK; reset is synchronous and active-high (CLEAR).
REQ-002 The block SHALL expose these ports:
- CLOCK  input  1  system clock, rising edge.
- CLEAR  input  1  synchronous active-high reset.
- REQ  input  2  REQ[i]=1 means requester i wants the shared 4-bit counter; held until DONE[i].
- LEN0  input  4  terminal count for requester 0; sampled only at grant.
- LEN1  input  4  terminal count for requester 1; sampled only at grant.
- GNT  output  2  one-hot owner of the counter; 00 when no owner.
- Q  output  4  shared counter value.
- BUSY  output  1  1 when the state is not IDLE.
- DONE  output  2  one-cycle completion pulse to the owner.

Function
REQ-003 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-004 The FSM SHALL have three states: IDLE, RUN and FIN.
REQ-005 In IDLE with REQ!=00, the next edge SHALL:
- enter RUN;
- set GNT to the one-hot winner;
- set Q=0;
- latch TERM from the winner's LEN.
REQ-006 The winner SHALL be chosen as follows:
- only one REQ bit set: that requester wins;
- both set: requester PTR wins.
REQ-007 In RUN, each edge SHALL act as follows:
- if REQ[owner]=0: abort;
- else if Q==TERM: go to FIN and hold Q;
- else: Q<=Q+1.
REQ-008 RUN SHALL therefore last TERM+1 cycles; with LEN=0, RUN lasts exactly one cycle and Q stays at 0.
REQ-009 In FIN, DONE[owner]=1 for exactly one cycle, GNT=00 and Q holds TERM.
REQ-010 On the next edge after FIN, the block SHALL do all of the following:
- go to IDLE;
- set Q=0 and DONE=00;
- set PTR to the non-owner.
REQ-011 An abort SHALL, on that edge, do all of the following:
- go to IDLE;
- set GNT=00 and Q=0;
- generate no DONE pulse;
- set PTR to the non-owner.
REQ-012 Abort SHALL take priority over the terminal match when both occur on the same edge.
REQ-013 Changes on LEN0/LEN1 after grant SHALL NOT affect TERM.
REQ-014 Changes on the non-owner's REQ during RUN or FIN SHALL NOT affect the FSM.
REQ-015 A new grant SHALL occur no earlier than the IDLE cycle following FIN, so the minimum gap between grants is 2 cycles (FIN plus IDLE).
REQ-016 Q SHALL never exceed 15 and SHALL never wrap; TERM bounds the count.
REQ-017 GNT SHALL have at most one bit set at all times, and DONE SHALL have at most one bit set at all times.

Reset
REQ-018 When CLEAR=1 at a rising edge, the block SHALL set:
- state=IDLE, Q=0000, GNT=00, DONE=00;
- BUSY=0, PTR=0, TERM=0000.
REQ-019 CLEAR SHALL override every other input in any state, including RUN and FIN.
REQ-020 When CLEAR interrupts RUN or FIN, no DONE pulse SHALL be emitted.
REQ-021 In the first cycle after CLEAR deasserts, the block SHALL behave as in IDLE, with PTR=0.

Verification
REQ-022 The bench SHALL cover these directed scenarios (clock period 20):
- Single request: REQ=01, LEN0=3 -> GNT=01; Q goes 0,1,2,3 over 4 RUN cycles; then one FIN cycle with DONE=01 and Q=3; then IDLE with Q=0.
- Contention: REQ=11 after reset -> requester 0 served first. With both REQs held, requester 1 is granted in the IDLE cycle after requester 0's FIN. Then requester 0 is granted next.
- Zero length: REQ=10, LEN1=0 -> one RUN cycle with Q=0; next cycle DONE=10.
- Abort: REQ=01, LEN0=9; drop REQ[0] when Q=4 -> next edge GNT=00, Q=0, no DONE. PTR=1, so a following REQ=11 grants requester 1.
- Reset mid-run: CLEAR=1 at Q=5 -> next edge all outputs are at reset values, and no DONE appears.
- LEN stability: change LEN0 from 6 to 2 while Q=1 -> the count still reaches 6 before DONE.
